// File: rtl/io_in_reader_pkg.sv
// io_in_reader_pkg: shared types and constants for the io_in_reader block.
//   - state enum of the main receive FSM and of the bus read sequencer
//   - register offsets (RSR/RBR) and default base address
//   - fi_set(): extracts the buffer-full flag from a captured RSR byte
package io_in_reader_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 16'h0ABC;
    localparam logic [ADDR_W-1:0] RSR_OFF           = 16'd0;
    localparam logic [ADDR_W-1:0] RBR_OFF           = 16'd1;

    // Main FSM: poll RSR (PA/PR/PS), read RBR (RA/RR/RS), handshake (H1-H3)
    typedef enum logic [3:0] {
        PA, PR, PS, RA, RR, RS, H1, H2, H3
    } rd_state_e;

    // Read sequencer: address setup, strobe low, address hold
    typedef enum logic [1:0] {
        SEQ_IDLE, SEQ_ADR, SEQ_STB, SEQ_HLD
    } seq_phase_e;

    // Masking keeps every RSR bit in the expression; only bit_pos matters
    function automatic logic fi_set(input logic [DATA_W-1:0] rsr,
                                    input int unsigned bit_pos);
        return |(rsr & (DATA_W'(1) << bit_pos));
    endfunction

endpackage

// File: rtl/io_read_cycle.sv
// io_read_cycle: generic 3-cycle I/O bus read sequencer.
//   Phases: ADR (addr driven, ior_=1) -> STB (ior_=0) -> HLD (ior_=1, addr held).
//   Data is captured on the edge leaving STB. A start seen in IDLE or HLD
//   loads tgt_addr and begins the next read back-to-back.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          begin a read at tgt_addr on the next edge
//   tgt_addr       address for the read being started
//   data_in        I/O data bus
//   addr, ior_     registered bus address and read strobe
//   rd_byte        byte captured by the most recent read
//   done_c         high during the hold phase (captured byte valid)
module io_read_cycle
    import io_in_reader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RST_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] tgt_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr,
    output logic              ior_,
    output logic [DATA_W-1:0] rd_byte,
    output logic              done_c
);

    seq_phase_e        ph_q, ph_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ior_q, ior_d;
    logic [DATA_W-1:0] rd_byte_q, rd_byte_d;

    // Next phase; addr only moves on entry to ADR so it is never changed
    // while the strobe is low or on a strobe edge
    always_comb begin
        ph_d      = ph_q;
        addr_d    = addr_q;
        rd_byte_d = rd_byte_q;
        case (ph_q)
            SEQ_IDLE: begin
                if (start) begin
                    ph_d   = SEQ_ADR;
                    addr_d = tgt_addr;
                end
            end
            SEQ_ADR:  ph_d = SEQ_STB;
            SEQ_STB: begin
                ph_d      = SEQ_HLD;
                rd_byte_d = data_in;
            end
            SEQ_HLD: begin
                if (start) begin
                    ph_d   = SEQ_ADR;
                    addr_d = tgt_addr;
                end else begin
                    ph_d = SEQ_IDLE;
                end
            end
            default:  ph_d = SEQ_IDLE;
        endcase
        ior_d = (ph_d != SEQ_STB);
    end

    // Reset parks the sequencer in address setup so the first read starts at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q      <= SEQ_ADR;
            addr_q    <= RST_ADDR;
            ior_q     <= 1'b1;
            rd_byte_q <= '0;
        end else begin
            ph_q      <= ph_d;
            addr_q    <= addr_d;
            ior_q     <= ior_d;
            rd_byte_q <= rd_byte_d;
        end
    end

    assign addr    = addr_q;
    assign ior_    = ior_q;
    assign rd_byte = rd_byte_q;
    assign done_c  = (ph_q == SEQ_HLD);

endmodule

// File: rtl/io_in_reader.sv
// io_in_reader: receive-side I/O bus master. Polls RSR at BASE_ADDR until the
// FI flag (bit FI_BIT) is set, reads RBR at BASE_ADDR+1, then delivers the
// byte to a local consumer over a dav_/rfd handshake. Never writes I/O space.
// Optional build macro: IO_IN_READER_DROP_ZERO_EN - discard RBR bytes of 8'h00.
// Ports:
//   clock, reset   clock, asynchronous active-high reset
//   addr           I/O address (BASE_ADDR or BASE_ADDR+1 only)
//   data           I/O data bus, never driven by this block
//   ior_, iow_     read strobe (active low), write strobe (held high)
//   byte_out       delivered byte
//   dav_           data valid, active low
//   rfd            consumer ready for data
module io_in_reader
    import io_in_reader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned       FI_BIT    = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              ior_,
    output logic              iow_,
    output logic [DATA_W-1:0] byte_out,
    output logic              dav_,
    input  logic              rfd
);

    localparam logic [ADDR_W-1:0] RSR_ADDR = BASE_ADDR + RSR_OFF;
    localparam logic [ADDR_W-1:0] RBR_ADDR = BASE_ADDR + RBR_OFF;
`ifdef IO_IN_READER_DROP_ZERO_EN
    localparam logic DROP_ZERO = 1'b1;
`else
    localparam logic DROP_ZERO = 1'b0;
`endif

    rd_state_e         state_q, state_d;
    logic              dav_q, dav_d;
    logic [DATA_W-1:0] byte_out_q, byte_out_d;
    logic              seq_start_c;
    logic [ADDR_W-1:0] seq_tgt_c;
    logic [DATA_W-1:0] seq_byte;
    logic              seq_done_c;

    assign data = 8'hzz;
    assign iow_ = 1'b1;

    io_read_cycle #(
        .RST_ADDR (RSR_ADDR)
    ) u_read (
        .clk      (clock),
        .rst      (reset),
        .start    (seq_start_c),
        .tgt_addr (seq_tgt_c),
        .data_in  (data),
        .addr     (addr),
        .ior_     (ior_),
        .rd_byte  (seq_byte),
        .done_c   (seq_done_c)
    );

    // Main sequencing of poll, read and handshake
    always_comb begin
        state_d     = state_q;
        dav_d       = dav_q;
        byte_out_d  = byte_out_q;
        seq_start_c = 1'b0;
        seq_tgt_c   = RSR_ADDR;
        case (state_q)
            PA: state_d = PR;
            PR: state_d = PS;
            PS: begin
                if (seq_done_c) begin
                    state_d = fi_set(seq_byte, FI_BIT) ? RA : PA;
                end
            end
            RA: state_d = RR;
            RR: begin
                state_d    = RS;
                byte_out_d = data;
            end
            RS: begin
                if (seq_done_c) begin
                    state_d = (DROP_ZERO && (byte_out_q == 8'h00)) ? PA : H1;
                end
            end
            H1: begin
                if (rfd) begin
                    dav_d   = 1'b0;
                    state_d = H2;
                end
            end
            H2: begin
                if (!rfd) begin
                    dav_d   = 1'b1;
                    state_d = H3;
                end
            end
            H3: begin
                if (rfd) state_d = PA;
            end
            default: state_d = PA;
        endcase
        // Kick the shared sequencer whenever a new read phase is entered
        if ((state_d == PA || state_d == RA) && !(state_q == PA || state_q == RA)) begin
            seq_start_c = 1'b1;
        end
        if (state_d == RA) seq_tgt_c = RBR_ADDR;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= PA;
            dav_q      <= 1'b1;
            byte_out_q <= '0;
        end else begin
            state_q    <= state_d;
            dav_q      <= dav_d;
            byte_out_q <= byte_out_d;
        end
    end

    assign dav_     = dav_q;
    assign byte_out = byte_out_q;

endmodule

// File: tb/tb_io_in_reader.sv
module tb_io_in_reader;

    localparam logic [15:0] RSR_A = 16'h0ABC;
    localparam logic [15:0] RBR_A = 16'h0ABD;

    logic        clock, reset, rfd;
    logic [15:0] addr;
    wire  [7:0]  data;
    logic        ior_, iow_, dav_;
    logic [7:0]  byte_out;

    io_in_reader dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .data     (data),
        .ior_     (ior_),
        .iow_     (iow_),
        .byte_out (byte_out),
        .dav_     (dav_),
        .rfd      (rfd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bus slave model: RSR answers idle for poll_n reads, then ready;
    // RBR answers rbr_a on its first read, rbr_b afterwards.
    int         poll_n, rsr_base, rbr_base;
    logic [7:0] rsr_idle, rsr_ready, rbr_a, rbr_b, resp;
    int         rsr_reads = 0, rbr_reads = 0, bad_reads = 0, proto_err = 0;

    always_comb begin
        if (addr == RSR_A)      resp = ((rsr_reads - rsr_base) < poll_n) ? rsr_idle : rsr_ready;
        else if (addr == RBR_A) resp = (rbr_reads == rbr_base) ? rbr_a : rbr_b;
        else                    resp = 8'hEE;
    end
    assign data = (!ior_) ? resp : 8'hzz;

    always @(posedge clock) begin
        if (!reset && !ior_) begin
            if (addr == RSR_A)      rsr_reads <= rsr_reads + 1;
            else if (addr == RBR_A) rbr_reads <= rbr_reads + 1;
            else                    bad_reads <= bad_reads + 1;
        end
    end

    // Bus protocol monitor
    logic [15:0] p_addr;
    logic        p_ior, p_rst;
    always @(negedge clock) begin
        p_addr <= addr;
        p_ior  <= ior_;
        p_rst  <= reset;
        if (!reset && !p_rst) begin
            if (addr != p_addr && (!p_ior || !ior_)) proto_err <= proto_err + 1;
            else if (!p_ior && !ior_)                proto_err <= proto_err + 1;
            else if (iow_ !== 1'b1)                  proto_err <= proto_err + 1;
            else if (addr != RSR_A && addr != RBR_A) proto_err <= proto_err + 1;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int pn, input logic [7:0] idle, input logic [7:0] ready,
                            input logic [7:0] a, input logic [7:0] b, input logic r);
        @(negedge clock);
        reset     = 1'b1;
        poll_n    = pn;
        rsr_idle  = idle;
        rsr_ready = ready;
        rbr_a     = a;
        rbr_b     = b;
        rfd       = r;
        @(negedge clock);
        rsr_base  = rsr_reads;
        rbr_base  = rbr_reads;
        reset     = 1'b0;
    endtask

    task automatic wait_dav(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            cyc++;
            if (!dav_) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_poll(input int budget, output bit ok);
        int r0;
        r0 = rsr_reads;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (rsr_reads > r0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int         pn;
        logic [7:0] idle;
        logic [7:0] ready;
        logic [7:0] rbr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[4];
    int   cyc;
    bit   ok, any_dav, any_ior, any_byte;
    int   r_rsr, r_rbr;

    initial begin
        vecs[0] = '{0, 8'h00, 8'h01, 8'h1A, 8'h1A};
        vecs[1] = '{3, 8'hFE, 8'hFF, 8'hA5, 8'hA5};
        vecs[2] = '{1, 8'h00, 8'h81, 8'h7E, 8'h7E};
        vecs[3] = '{5, 8'h02, 8'h03, 8'hFF, 8'hFF};

        reset = 1'b1; rfd = 1'b1; poll_n = 1000;
        rsr_base = 0; rbr_base = 0;
        rsr_idle = 8'h00; rsr_ready = 8'h01; rbr_a = 8'h00; rbr_b = 8'h00;
        repeat (2) @(negedge clock);
        chk("reset_addr", 32'(addr), 32'h0ABC);
        chk("reset_ior", 32'(ior_), 32'h1);
        chk("reset_iow", 32'(iow_), 32'h1);
        chk("reset_dav", 32'(dav_), 32'h1);
        chk("reset_byte", 32'(byte_out), 32'h0);

        // Table: poll count, FI detect, RBR delivery and handshake
        foreach (vecs[i]) begin
            do_reset(vecs[i].pn, vecs[i].idle, vecs[i].ready, vecs[i].rbr, 8'h33, 1'b1);
            wait_dav(200, cyc, ok);
            chk($sformatf("v%0d_dav_low", i), 32'(ok), 32'h1);
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(3 * vecs[i].pn + 7));
            chk($sformatf("v%0d_byte", i), 32'(byte_out), 32'(vecs[i].exp));
            chk($sformatf("v%0d_rsr_reads", i), 32'(rsr_reads - rsr_base), 32'(vecs[i].pn + 1));
            chk($sformatf("v%0d_rbr_reads", i), 32'(rbr_reads - rbr_base), 32'h1);
            rfd = 1'b0;
            @(negedge clock);
            chk($sformatf("v%0d_dav_high", i), 32'(dav_), 32'h1);
            rfd = 1'b1;
            wait_poll(10, ok);
            chk($sformatf("v%0d_poll_resume", i), 32'(ok), 32'h1);
        end

        // Reset asserted while ior_ is low
        do_reset(1000, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1);
        @(negedge clock);
        chk("midpr_ior_low", 32'(ior_), 32'h0);
        reset = 1'b1;
        #1;
        chk("midpr_ior", 32'(ior_), 32'h1);
        chk("midpr_dav", 32'(dav_), 32'h1);
        chk("midpr_addr", 32'(addr), 32'h0ABC);
        chk("midpr_byte", 32'(byte_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midpr_first_fall", 32'(ior_), 32'h0);

        // Ten empty polls: one RSR read every 3 cycles, no RBR access
        do_reset(1000, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1);
        repeat (28) @(negedge clock);
        chk("poll10_at28", 32'(rsr_reads - rsr_base), 32'd9);
        repeat (2) @(negedge clock);
        chk("poll10_at30", 32'(rsr_reads - rsr_base), 32'd10);
        chk("poll10_rbr", 32'(rbr_reads - rbr_base), 32'd0);

        // FI clear with every other RSR bit set
        do_reset(1000, 8'hFE, 8'h01, 8'h00, 8'h00, 1'b1);
        repeat (60) @(negedge clock);
        chk("fe_rsr_reads", 32'(rsr_reads - rsr_base), 32'd20);
        chk("fe_rbr_reads", 32'(rbr_reads - rbr_base), 32'd0);
        chk("fe_dav", 32'(dav_), 32'h1);

        // Consumer not ready for 50 cycles after the RBR read
        do_reset(0, 8'h00, 8'h01, 8'h1A, 8'h33, 1'b0);
        repeat (6) @(negedge clock);
        r_rsr = rsr_reads; r_rbr = rbr_reads;
        any_dav = 1'b0; any_ior = 1'b0; any_byte = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (!dav_) any_dav = 1'b1;
            if (!ior_) any_ior = 1'b1;
            if (byte_out !== 8'h1A) any_byte = 1'b1;
        end
        chk("hold_dav_low_seen", 32'(any_dav), 32'h0);
        chk("hold_ior_low_seen", 32'(any_ior), 32'h0);
        chk("hold_byte_changed", 32'(any_byte), 32'h0);
        chk("hold_reads", 32'((rsr_reads - r_rsr) + (rbr_reads - r_rbr)), 32'h0);
        rfd = 1'b1;
        @(negedge clock);
        chk("hold_dav_fall", 32'(dav_), 32'h0);
        chk("hold_byte", 32'(byte_out), 32'h1A);
        rfd = 1'b0;
        @(negedge clock);
        chk("hold_dav_rise", 32'(dav_), 32'h1);
        rfd = 1'b1;

        // Zero byte followed by 8'h5C
        do_reset(0, 8'h00, 8'h01, 8'h00, 8'h5C, 1'b1);
        wait_dav(200, cyc, ok);
        chk("zero_dav1", 32'(ok), 32'h1);
`ifndef IO_IN_READER_DROP_ZERO_EN
        chk("zero_first_byte", 32'(byte_out), 32'h00);
        rfd = 1'b0;
        @(negedge clock);
        rfd = 1'b1;
        wait_dav(200, cyc, ok);
        chk("zero_dav2", 32'(ok), 32'h1);
`endif
        chk("zero_second_byte", 32'(byte_out), 32'h5C);
        chk("zero_rbr_reads", 32'(rbr_reads - rbr_base), 32'd2);
        rfd = 1'b0;
        @(negedge clock);
        rfd = 1'b1;
        repeat (3) @(negedge clock);

        chk("bad_addr_reads", 32'(bad_reads), 32'd0);
        chk("bus_protocol", 32'(proto_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_in_reader.md
# io_in_reader

Bus-master block that pulls bytes from a handshake input interface on the 16-bit I/O bus and hands each byte to a local consumer. It is the receive-side counterpart of our write-side master: it polls the interface status register (RSR) until the FI (buffer full) flag is set, reads the buffer register (RBR), and delivers the byte over a `dav_`/`rfd` handshake. The block never writes the I/O space.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0ABC: RSR address (must be even); RBR is at `BASE_ADDR+1`.
- `FI_BIT`, 0: bit position of the FI flag in RSR.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  out  16  I/O address.
- `data`  inout  8  I/O data bus; the block never drives it (constant 8'hZZ).
- `ior_`  out  1  I/O read strobe, active low.
- `iow_`  out  1  I/O write strobe, active low; held at 1.
- `byte_out`  out  8  delivered byte.
- `dav_`  out  1  data valid, active low.
- `rfd`  in  1  consumer ready for data.

## Operation
- Reset (asynchronous, effective immediately, including mid-bus-cycle): `ior_`=1, `iow_`=1, `addr`=BASE_ADDR, `dav_`=1, `byte_out`=8'h00, state PA.
- States:
  - PA: `addr`=BASE_ADDR, `ior_`=1 -> PR.
  - PR: `ior_`=0 -> PS. `data` is captured into an internal register on the edge leaving PR.
  - PS: `ior_`=1. If captured bit FI_BIT = 1 -> RA, else -> PA.
  - RA: `addr`=BASE_ADDR+1, `ior_`=1 -> RR.
  - RR: `ior_`=0 -> RS. `data` is captured into `byte_out` on the edge leaving RR.
  - RS: `ior_`=1 -> H1.
  - H1: wait while `rfd`=0. When `rfd`=1, set `dav_`=0 -> H2.
  - H2: wait while `rfd`=1. When `rfd`=0, set `dav_`=1 -> H3.
  - H3: wait while `rfd`=0. When `rfd`=1 -> PA.
- `byte_out` is stable from the RR exit edge until the next RR exit edge. It is therefore stable through the whole `dav_`=0 window.
- RSR bits other than FI_BIT are ignored.
- Only `addr` values BASE_ADDR and BASE_ADDR+1 are ever driven.
- The block takes no action on `data` outside the PR and RR capture edges.

## Timing
- Each bus read takes 3 cycles:
  - `addr` is stable 1 cycle before `ior_` falls.
  - `ior_` is low for exactly 1 cycle.
  - `addr` is held for 1 cycle after `ior_` rises.
- `addr` never changes while `ior_`=0, and never changes in the same cycle `ior_` falls or rises.
- Poll loop with FI=0: 3 cycles per RSR read, repeating indefinitely.
- FI seen to `dav_` low, consumer already ready: 3 cycles for the RBR read, then `dav_` falls on the H1 exit edge. Minimum 4 cycles from the PS exit edge.
- `rfd` is sampled once per clock.
  - `rfd` toggling within one cycle may be missed.
  - The consumer must hold each `rfd` level for at least 1 cycle.
- The consumer must not drop `rfd` before `dav_`=0. The block ignores `rfd` outside H1–H3.

## Configuration
- Macro `IO_IN_READER_DROP_ZERO_EN`:
  - Defined: in RS, a captured byte of 8'h00 is discarded. The next state is PA, no handshake occurs, and `dav_` stays 1.
  - Undefined: every byte read from RBR, including 8'h00, is delivered.

## Structure
- Package `io_in_reader_pkg` holds:
  - the state enum (PA, PR, PS, RA, RR, RS, H1, H2, H3);
  - the register offsets RSR_OFF=0 and RBR_OFF=1;
  - the default base address 16'h0ABC.
- Sub-module `io_read_cycle`: a generic 3-cycle bus read sequencer.
  - Inputs: start and target address. Outputs: `addr`, `ior_`, captured byte, done.
  - Instantiated once and shared by the RSR and RBR reads. The main FSM then sequences poll, read and handshake.

## Test plan
- Reset asserted mid-PR (`ior_`=0) -> `ior_`=1 and `dav_`=1 in the same timestep; `addr`=16'h0ABC. After release, the first `ior_` fall comes 1 cycle later.
- RSR returns 8'h00 for 10 polls -> 10 reads at 16'h0ABC, 3 cycles apart, with no access to 16'h0ABD. A catch-all model at any other address must flag nothing.
- RSR=8'h01, RBR=8'h1A, `rfd`=1 -> one read at 16'h0ABD, then `dav_`=0 with `byte_out`=8'h1A. Drop `rfd` -> `dav_`=1 one edge later. Raise `rfd` -> polling resumes.
- Consumer holds `rfd`=0 for 50 cycles after the RBR read -> `dav_` stays 1, no bus activity, `byte_out` stays 8'h1A.
- RSR=8'hFE (FI=0, other bits set) -> the block keeps polling and never reads RBR.
- RBR=8'h00 then 8'h5C:
  - with `IO_IN_READER_DROP_ZERO_EN` -> only 8'h5C is delivered;
  - without it -> 8'h00 then 8'h5C are delivered in order.
